ham_dist_arbiter: RTL and testbench
===================================

// Module: ham_dist_arbiter
// PURPOSE
//  Shares one 32-bit Hamming-weight (popcount) datapath between NREQ requesters.
//  Each requester offers an operand pair (A,B). The block grants round-robin,
//  registers A^B, and returns the Hamming distance popcount(A^B) with the
//  requester ID over a valid/ready response channel.
//  Sits between the bit-vector clients and the shared popcount adder tree.
// PARAMETERS
//  NREQ  4   number of requesters (2..8)
//  W     32  operand width; the shared datapath is fixed at 32, so W must be 32
//  CW    6   result width = $clog2(W+1)
//  IDW   2   requester-ID width = $clog2(NREQ)
// PORTS
//  clk         in   1         single clock, rising edge
//  rst_n       in   1         asynchronous reset, active low
//  req_valid   in   NREQ      per-requester request valid
//  req_a       in   NREQ*W    operand A; slice i = [i*W +: W]
//  req_b       in   NREQ*W    operand B; slice i = [i*W +: W]
//  req_ready   out  NREQ      one-hot grant/accept; combinational from state and req_valid
//  rsp_valid   out  1         response valid
//  rsp_id      out  IDW       index of the requester being answered
//  rsp_weight  out  CW        popcount(A^B), range 0..32
//  rsp_ready   in   1         response consumer ready
//  busy        out  1         high in every state except IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, rsp_valid=0, rsp_id=0, rsp_weight=0,
//    busy=0, operand reg=0, rr_ptr=NREQ-1, so requester 0 has first priority.
//  FSM IDLE -> CALC -> HOLD -> IDLE.
//  - IDLE: if |req_valid, grant g = first valid index searching from rr_ptr+1
//    (mod NREQ), upward. req_ready[g]=1 this cycle only; accept happens at this edge.
//    Capture opx <= req_a[g]^req_b[g] and id_q <= g, then go to CALC.
//    If no request is valid, stay in IDLE and keep req_ready=0.
//  - CALC: rsp_weight <= popcount(opx), rsp_id <= id_q, rsp_valid <= 1; go to HOLD.
//  - HOLD: hold rsp_* stable while rsp_ready=0. On rsp_valid&rsp_ready:
//    rsp_valid <= 0, rr_ptr <= id_q, go to IDLE.
//  req_ready is 0 in CALC and HOLD. At most one bit of req_ready is high in any cycle.
//  Latency: accept at edge t gives rsp_valid=1 from edge t+2. Best-case throughput
//    is 1 result every 3 cycles.
//  Arithmetic: zero-extend the popcount to CW. All-ones XOR gives 32 (6'b100000).
//  Requesters hold valid and operands until their ready bit is seen. The block
//    samples operands only at the accept edge; later operand changes are ignored.
//  A requester that deasserts valid before being granted is not served and
//    leaves no state behind.
//  Simultaneous events: the rsp handshake and new requests in the same cycle
//    are handled as follows. The handshake completes, and arbitration happens
//    in the next (IDLE) cycle using the updated rr_ptr.
//  Fairness: a continuously requesting client waits at most NREQ-1 other grants.
//  Reset mid-operation: a pending or held response is discarded (rsp_valid
//    drops asynchronously) and arbitration restarts at requester 0.
//  No X on outputs after reset. req_ready is gated by req_valid.
// STRUCTURE
//  Shared package ham_pkg: localparam HAM_W=32, HAM_CW=6; typedef of the
//    state enum {IDLE,CALC,HOLD}; ham_id_t sized by IDW.
//  Sub-module rr_arbiter (NREQ): inputs req and ptr; output is a one-hot grant
//    plus its encoded index.
//  Instantiate the existing 32-bit popcount adder tree as the shared datapath.
//  Place it between opx and the rsp_weight register only.
//  Estimated size is about 150-250 lines.
// TESTING
//  1 Reset, then req_valid=4'b0001, A0=32'hFFFF_0000, B0=32'h0000_0000 ->
//    req_ready=0001 for 1 cycle. rsp_valid at +2, rsp_id=0, rsp_weight=16.
//  2 All four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0.
//    Each rsp_id matches its grant. Every requester's A=~B gives rsp_weight=32.
//  3 rsp_ready=0 for 5 cycles while req_valid=1111 -> rsp_* stable and
//    req_ready=0000 throughout. The next grant goes to (id_q+1) only after the handshake.
//  4 A==B (32'hDEAD_BEEF) -> rsp_weight=0. A=1, B=0 -> rsp_weight=1.
//  5 Assert rst_n=0 in HOLD -> rsp_valid drops immediately. After release,
//    req_valid=1010 -> requester 1 is granted first.
//  6 Requester 2 drops valid before its turn -> it is never granted.
//    The assertion onehot0(req_ready) holds for the whole run.

Source files
------------

// File: rtl/ham_pkg.sv
// Shared definitions for the Hamming-distance arbiter slice.
package ham_pkg;

  localparam int HAM_W    = 32;
  localparam int HAM_CW   = 6;
  localparam int HAM_NREQ = 4;
  localparam int HAM_IDW  = $clog2(HAM_NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } ham_state_t;

  typedef logic [HAM_IDW-1:0] ham_id_t;

endpackage

// File: rtl/ham_dist_arbiter_popcount.sv
// Shared 32-bit popcount adder tree (purely combinational, five levels).
module ham_popcount32
  import ham_pkg::*;
(
  input  logic [HAM_W-1:0]  x,
  output logic [HAM_CW-1:0] cnt
);

  logic [1:0] l1 [16];
  logic [2:0] l2 [8];
  logic [3:0] l3 [4];
  logic [4:0] l4 [2];

  // Pairwise reduction: 32 bits -> 16 x 2b -> 8 x 3b -> 4 x 4b -> 2 x 5b -> 6b.
  always_comb begin
    for (int i = 0; i < 16; i++) l1[i] = {1'b0, x[2*i]} + {1'b0, x[2*i+1]};
    for (int i = 0; i < 8; i++)  l2[i] = {1'b0, l1[2*i]} + {1'b0, l1[2*i+1]};
    for (int i = 0; i < 4; i++)  l3[i] = {1'b0, l2[2*i]} + {1'b0, l2[2*i+1]};
    for (int i = 0; i < 2; i++)  l4[i] = {1'b0, l3[2*i]} + {1'b0, l3[2*i+1]};
    cnt = {1'b0, l4[0]} + {1'b0, l4[1]};
  end

endmodule

// File: rtl/ham_dist_arbiter_rr.sv
// Round-robin arbiter: searches upward from ptr+1 (mod NREQ) for the first
// active request and returns a one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  // One spare bit so ptr+k never overflows before the modulo fold.
  logic [IDW:0] cand;

  // Priority scan starting just after the last served requester.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!any && req[cand[IDW-1:0]]) begin
        any                 = 1'b1;
        gnt[cand[IDW-1:0]]  = 1'b1;
        idx                 = cand[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/ham_dist_arbiter.sv
// Round-robin front end for a single shared 32-bit popcount datapath.
// Grants one requester, registers A^B, returns popcount(A^B) with the ID.
module ham_dist_arbiter
  import ham_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 32,          // shared datapath is fixed at 32 bits
  parameter int CW   = $clog2(W+1),
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [CW-1:0]     rsp_weight,
  input  logic              rsp_ready,
  output logic              busy
);

  ham_state_t          state;
  logic [W-1:0]        opx;
  logic [IDW-1:0]      id_q;
  logic [IDW-1:0]      rr_ptr;
  logic [NREQ-1:0]     gnt;
  logic [IDW-1:0]      gnt_idx;
  logic                gnt_any;
  logic [W-1:0]        xor_sel;
  logic [HAM_CW-1:0]   pc;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  // Grants are only visible while waiting for work; gnt is already gated by req_valid.
  assign req_ready = (state == IDLE) ? gnt : '0;

  // One-hot mux of the granted operand pair, XORed ahead of the capture register.
  always_comb begin
    xor_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) xor_sel = req_a[i*W +: W] ^ req_b[i*W +: W];
    end
  end

  // Shared adder tree sits between the opx register and the rsp_weight register.
  ham_popcount32 u_pc (
    .x   (opx),
    .cnt (pc)
  );

  // Control FSM with registered response outputs: IDLE -> CALC -> HOLD -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      opx        <= '0;
      id_q       <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_weight <= '0;
      busy       <= 1'b0;
      rr_ptr     <= IDW'(NREQ-1);
    end else begin
      case (state)
        // accept edge: operands sampled here only
        IDLE: begin
          if (gnt_any) begin
            opx   <= xor_sel;
            id_q  <= gnt_idx;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        // opx -> popcount -> response register
        CALC: begin
          rsp_weight <= CW'(pc);
          rsp_id     <= id_q;
          rsp_valid  <= 1'b1;
          state      <= HOLD;
        end
        // response held until consumed; pointer advances only on handshake
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= id_q;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ham_dist_arbiter.sv
// Directed bench for ham_dist_arbiter with hand-computed expectations.
module tb_ham_dist_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int CW   = 6;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [CW-1:0]     rsp_weight;
  logic              rsp_ready;
  logic              busy;

  logic [W-1:0] a [NREQ];
  logic [W-1:0] b [NREQ];

  int  n_chk = 0;
  int  n_err = 0;
  bit  mon_en = 1'b0;

  ham_dist_arbiter #(
    .NREQ (NREQ),
    .W    (W),
    .CW   (CW),
    .IDW  (IDW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_weight (rsp_weight),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = a[i];
      req_b[i*W +: W] = b[i];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // At most one ready bit in any cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) chk("onehot_ready", {63'b0, $onehot0(req_ready)}, 64'd1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_rsp_valid",  rsp_valid,  0);
    chk("rst_rsp_id",     rsp_id,     0);
    chk("rst_rsp_weight", rsp_weight, 0);
    chk("rst_busy",       busy,       0);
    chk("rst_req_ready",  req_ready,  0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called on a falling edge in IDLE with inputs set; returns on the falling
  // edge after the handshake (rsp_ready must be 1).
  task automatic run_one(input int g, input logic [CW-1:0] w, input bit drop);
    #1;
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("idle_busy",      busy,      0);
    chk("grant",          req_ready, 64'(1) << g);
    @(negedge clk);
    if (drop) req_valid[g] = 1'b0;
    #1;
    chk("calc_ready", req_ready, 0);
    chk("calc_busy",  busy,      1);
    chk("calc_valid", rsp_valid, 0);
    @(negedge clk);
    #1;
    chk("hold_valid",  rsp_valid,  1);
    chk("hold_id",     rsp_id,     g);
    chk("hold_weight", rsp_weight, w);
    chk("hold_ready",  req_ready,  0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      a[i] = '0;
      b[i] = '0;
    end

    // 1: single requester, weight 16
    do_reset();
    mon_en    = 1'b1;
    a[0]      = 32'hFFFF_0000;
    b[0]      = 32'h0000_0000;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    run_one(0, 6'd16, 1'b1);
    #1;
    chk("t1_after_ready", req_ready, 0);
    chk("t1_after_valid", rsp_valid, 0);

    // 2: all requesting, A=~B, round-robin order 0,1,2,3,0
    do_reset();
    a[0] = 32'h1234_5678; a[1] = 32'hA5A5_0F0F;
    a[2] = 32'h0000_0000; a[3] = 32'hFFFF_FFFF;
    for (int i = 0; i < NREQ; i++) b[i] = ~a[i];
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    run_one(0, 6'd32, 1'b0);
    run_one(1, 6'd32, 1'b0);
    run_one(2, 6'd32, 1'b0);
    run_one(3, 6'd32, 1'b0);
    run_one(0, 6'd32, 1'b0);

    // 3: response back-pressure for 5 cycles, late operand change ignored
    rsp_ready = 1'b0;
    a[1]      = 32'h0000_00FF;
    b[1]      = 32'h0000_0000;
    #1;
    chk("t3_grant", req_ready, 4'b0010);
    @(negedge clk);
    a[1] = 32'hFFFF_FFFF;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t3_hold_valid",  rsp_valid,  1);
      chk("t3_hold_id",     rsp_id,     1);
      chk("t3_hold_weight", rsp_weight, 8);
      chk("t3_hold_ready",  req_ready,  0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("t3_released", rsp_valid, 0);
    run_one(2, 6'd32, 1'b0);
    req_valid = '0;

    // 4: A==B gives 0, single bit gives 1
    do_reset();
    a[0] = 32'hDEAD_BEEF; b[0] = 32'hDEAD_BEEF;
    a[1] = 32'h0000_0001; b[1] = 32'h0000_0000;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    run_one(0, 6'd0, 1'b1);
    req_valid = 4'b0010;
    run_one(1, 6'd1, 1'b1);

    // 5: reset while holding a response
    do_reset();
    a[0] = 32'h0F0F_0F0F; b[0] = 32'h0000_0000;
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    #1;
    chk("t5_grant", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("t5_hold_valid",  rsp_valid,  1);
    chk("t5_hold_weight", rsp_weight, 16);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid",  rsp_valid,  0);
    chk("t5_async_busy",   busy,       0);
    chk("t5_async_weight", rsp_weight, 0);
    @(negedge clk);
    rst_n = 1'b1;
    a[1] = 32'h8000_0001; b[1] = 32'h0000_0000;
    a[3] = 32'hF000_000F; b[3] = 32'h0000_0000;
    req_valid = 4'b1010;
    rsp_ready = 1'b1;
    run_one(1, 6'd2, 1'b0);
    run_one(3, 6'd8, 1'b0);
    req_valid = '0;

    // 6: requester 2 withdraws before its turn and is skipped
    do_reset();
    a[0] = 32'h0000_0003; b[0] = 32'h0000_0000;
    a[1] = 32'h0000_0007; b[1] = 32'h0000_0000;
    a[2] = 32'h0000_00FF; b[2] = 32'h0000_0000;
    a[3] = 32'h0000_000F; b[3] = 32'h0000_0000;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    run_one(0, 6'd2, 1'b0);
    req_valid = 4'b1011;
    run_one(1, 6'd3, 1'b0);
    run_one(3, 6'd4, 1'b0);
    run_one(0, 6'd2, 1'b0);
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("t6_idle_ready", req_ready, 0);
    chk("t6_idle_busy",  busy,      0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
